// File: rtl/fc_bus_arb.sv
// Address-port arbiter for the FC unit: grants read or write controller access to the
// shared bus address lines, tracks outstanding read bursts and serialises write bursts.
module fc_bus_arb #(
  parameter int ADDR_W     = 28,
  parameter int LEN_W      = 4,
  parameter int ID_W       = 4,
  parameter int MAX_RD_OUT = 4,
  localparam int CNT_W     = $clog2(MAX_RD_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [LEN_W-1:0]  rd_req_len,
  input  logic [ID_W-1:0]   rd_req_id,
  input  logic              rd_req_ap,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [LEN_W-1:0]  wr_req_len,
  input  logic [ID_W-1:0]   wr_req_id,
  input  logic              wr_req_ap,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LEN_W-1:0]  bus_len,
  output logic [ID_W-1:0]   bus_id,
  output logic              bus_ap,
  output logic              bus_arvalid,
  input  logic              bus_arready,
  output logic              bus_awvalid,
  input  logic              bus_awready,
  input  logic              bus_wready,
  input  logic              bus_wlast,
  input  logic [ID_W-1:0]   bus_wid,
  input  logic              bus_rvalid,
  input  logic              bus_rlast,
  output logic [CNT_W-1:0]  rd_outstanding,
  output logic              err_sticky
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, WR_ADDR, WR_DATA} state_t;

  state_t     state, state_next;
  logic       last_wr;          // 1 when the most recent grant went to the write side
  logic       rd_ok, wr_ok;
  logic       grant_rd, grant_wr;
  logic       wid_err;
  logic       rd_inc, rd_dec, rd_underflow;

  assign rd_ok = rd_req_valid && (rd_outstanding < CNT_W'(MAX_RD_OUT));
  assign wr_ok = wr_req_valid;

  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    wid_err    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_ok && wr_ok) begin
          grant_rd = last_wr;
          grant_wr = !last_wr;
        end else begin
          grant_rd = rd_ok;
          grant_wr = wr_ok;
        end
        if (grant_rd)      state_next = RD_ADDR;
        else if (grant_wr) state_next = WR_ADDR;
      end
      RD_ADDR: if (bus_arready) state_next = IDLE;
      WR_ADDR: if (bus_awready) state_next = WR_DATA;
      WR_DATA: begin
        // A last beat tagged with a foreign id cannot close our burst
        if (bus_wready && bus_wlast) begin
          if (bus_wid == bus_id) state_next = IDLE;
          else                   wid_err    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_req_ready = grant_rd;
  assign wr_req_ready = grant_wr;
  assign bus_arvalid  = (state == RD_ADDR);
  assign bus_awvalid  = (state == WR_ADDR);

  assign rd_inc       = (state == RD_ADDR) && bus_arready;
  assign rd_dec       = bus_rvalid && bus_rlast;
  assign rd_underflow = rd_dec && !rd_inc && (rd_outstanding == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_wr <= 1'b1;
    end else begin
      state <= state_next;
      if (grant_rd)      last_wr <= 1'b0;
      else if (grant_wr) last_wr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr <= '0;
      bus_len  <= '0;
      bus_id   <= '0;
      bus_ap   <= 1'b0;
    end else if (grant_rd) begin
      bus_addr <= rd_req_addr;
      bus_len  <= rd_req_len;
      bus_id   <= rd_req_id;
      bus_ap   <= rd_req_ap;
    end else if (grant_wr) begin
      bus_addr <= wr_req_addr;
      bus_len  <= wr_req_len;
      bus_id   <= wr_req_id;
      bus_ap   <= wr_req_ap;
    end
  end

  // Simultaneous accept and completion cancel out; an orphan rlast leaves the count at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_outstanding <= '0;
      err_sticky     <= 1'b0;
    end else begin
      if (rd_inc && !rd_dec)
        rd_outstanding <= rd_outstanding + CNT_W'(1);
      else if (rd_dec && !rd_inc && (rd_outstanding != '0))
        rd_outstanding <= rd_outstanding - CNT_W'(1);
      if (wid_err || rd_underflow)
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_bus_arb.sv
// Directed bench for fc_bus_arb: expected address-phase transactions go into a
// scoreboard queue, a negedge monitor pops and compares each bus handshake.
module tb_fc_bus_arb;

  localparam int ADDR_W = 28;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;
  localparam int MAXR   = 4;
  localparam int CNT_W  = $clog2(MAXR + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [ID_W-1:0]   id;
    logic              ap;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_req_valid = 0, wr_req_valid = 0;
  logic rd_req_ready, wr_req_ready;
  logic [ADDR_W-1:0] rd_req_addr = '0, wr_req_addr = '0;
  logic [LEN_W-1:0]  rd_req_len = '0, wr_req_len = '0;
  logic [ID_W-1:0]   rd_req_id = '0, wr_req_id = '0;
  logic rd_req_ap = 0, wr_req_ap = 0;
  logic [ADDR_W-1:0] bus_addr;
  logic [LEN_W-1:0]  bus_len;
  logic [ID_W-1:0]   bus_id;
  logic bus_ap, bus_arvalid, bus_awvalid;
  logic bus_arready = 0, bus_awready = 0, bus_wready = 0, bus_wlast = 0;
  logic [ID_W-1:0] bus_wid = '0;
  logic bus_rvalid = 0, bus_rlast = 0;
  logic [CNT_W-1:0] rd_outstanding;
  logic err_sticky;

  int tests = 0;
  int fails = 0;
  txn_t exp_q[$];

  fc_bus_arb #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .MAX_RD_OUT(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_id(rd_req_id), .rd_req_ap(rd_req_ap),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_req_id(wr_req_id), .wr_req_ap(wr_req_ap),
    .bus_addr(bus_addr), .bus_len(bus_len), .bus_id(bus_id), .bus_ap(bus_ap),
    .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
    .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
    .bus_wready(bus_wready), .bus_wlast(bus_wlast), .bus_wid(bus_wid),
    .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast),
    .rd_outstanding(rd_outstanding), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expected transaction per address handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_arvalid && bus_awvalid) begin
        tests++; fails++;
        $display("FAIL both_valid: arvalid=1 awvalid=1 required at most one");
      end
      if (rd_req_ready && wr_req_ready) begin
        tests++; fails++;
        $display("FAIL both_ready: rd_req_ready=1 wr_req_ready=1 required at most one");
      end
      if ((bus_arvalid && bus_arready) || (bus_awvalid && bus_awready)) begin
        txn_t act, expt;
        act = '{wr: bus_awvalid, addr: bus_addr, len: bus_len, id: bus_id, ap: bus_ap};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL txn_unexpected: got %h required none", act);
        end else begin
          expt = exp_q.pop_front();
          if (act !== expt) begin
            fails++;
            $display("FAIL txn: got %h required %h", act, expt);
          end else
            $display("[TB] txn %s addr=%h len=%0d id=%0d ap=%0d",
                     act.wr ? "WR" : "RD", act.addr, act.len, act.id, act.ap);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, expv);
    end
  endtask

  function automatic void push(input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [LEN_W-1:0] l, input logic [ID_W-1:0] i,
                               input logic ap);
    txn_t t;
    t = '{wr: wr, addr: a, len: l, id: i, ap: ap};
    exp_q.push_back(t);
  endfunction

  // Returns at the negedge where the requested ready is seen (bounded)
  task automatic wait_grant(input string nm, input bit wr, input int limit);
    bit seen = 0;
    int n = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      if (wr ? wr_req_ready : rd_req_ready) seen = 1;
      n++;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic rlast_pulse();
    bus_rvalid = 1; bus_rlast = 1;
    cyc();
    bus_rvalid = 0; bus_rlast = 0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                        input logic [ID_W-1:0] i, input logic ap);
    rd_req_addr = a; rd_req_len = l; rd_req_id = i; rd_req_ap = ap;
  endtask

  task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                        input logic [ID_W-1:0] i, input logic ap);
    wr_req_addr = a; wr_req_len = l; wr_req_id = i; wr_req_ap = ap;
  endtask

  initial begin
    int grants, n, acc;
    // Power-on reset
    cyc();
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_len", 32'(bus_len), 0);
    chk("rst_id", 32'(bus_id), 0);
    chk("rst_ap", 32'(bus_ap), 0);
    chk("rst_arvalid", 32'(bus_arvalid), 0);
    chk("rst_awvalid", 32'(bus_awvalid), 0);
    chk("rst_cnt", 32'(rd_outstanding), 0);
    chk("rst_err", 32'(err_sticky), 0);
    @(negedge clk); rst_n = 1;
    cyc();

    // Tie-break alternation starting with RD
    set_rd(28'h0AAA000, 4'd1, 4'd1, 1'b0);
    set_wr(28'h0BBB000, 4'd2, 4'd7, 1'b1);
    bus_arready = 1; bus_awready = 1; bus_wready = 1; bus_wlast = 1; bus_wid = 4'd7;
    push(0, 28'h0AAA000, 4'd1, 4'd1, 1'b0);
    push(1, 28'h0BBB000, 4'd2, 4'd7, 1'b1);
    push(0, 28'h0AAA000, 4'd1, 4'd1, 1'b0);
    push(1, 28'h0BBB000, 4'd2, 4'd7, 1'b1);
    rd_req_valid = 1; wr_req_valid = 1;
    grants = 0; n = 0;
    while (grants < 4 && n < 40) begin
      @(negedge clk);
      if (rd_req_ready || wr_req_ready) grants++;
      n++;
    end
    chk("alt_grants", 32'(grants), 4);
    cyc();
    rd_req_valid = 0; wr_req_valid = 0;
    repeat (4) cyc();
    bus_arready = 0; bus_awready = 0; bus_wready = 0; bus_wlast = 0;
    chk("alt_cnt", 32'(rd_outstanding), 2);
    rlast_pulse(); rlast_pulse();
    chk("alt_drain", 32'(rd_outstanding), 0);

    // Single read, arready two cycles after arvalid rises
    set_rd(28'h0000100, 4'd3, 4'd2, 1'b1);
    push(0, 28'h0000100, 4'd3, 4'd2, 1'b1);
    rd_req_valid = 1;
    @(negedge clk);
    chk("rd1_ready", 32'(rd_req_ready), 1);
    chk("rd1_wready", 32'(wr_req_ready), 0);
    cyc();
    rd_req_valid = 0;
    @(negedge clk);
    chk("rd1_arvalid_c1", 32'(bus_arvalid), 1);
    chk("rd1_addr", 32'(bus_addr), 32'h0000100);
    chk("rd1_ready_off", 32'(rd_req_ready), 0);
    cyc();
    @(negedge clk);
    chk("rd1_arvalid_c2", 32'(bus_arvalid), 1);
    cyc();
    bus_arready = 1;
    @(negedge clk);
    chk("rd1_arvalid_c3", 32'(bus_arvalid), 1);
    chk("rd1_len", 32'(bus_len), 3);
    cyc();
    bus_arready = 0;
    chk("rd1_arvalid_off", 32'(bus_arvalid), 0);
    chk("rd1_cnt", 32'(rd_outstanding), 1);
    rlast_pulse();
    chk("rd1_drain", 32'(rd_outstanding), 0);
    chk("rd1_hold_addr", 32'(bus_addr), 32'h0000100);

    // Outstanding-read limit
    for (int i = 0; i < 5; i++) push(0, 28'h0001000 + 28'(i), 4'd0, 4'(i), 1'b0);
    set_rd(28'h0001000, 4'd0, 4'd0, 1'b0);
    bus_arready = 1; rd_req_valid = 1;
    acc = 0; n = 0;
    while (acc < 4 && n < 40) begin
      @(negedge clk);
      if (rd_req_ready) begin
        acc++;
        cyc();
        set_rd(28'h0001000 + 28'(acc), 4'd0, 4'(acc), 1'b0);
      end
      n++;
    end
    chk("lim_accepted", 32'(acc), 4);
    repeat (6) begin
      @(negedge clk);
      chk("lim_stall", 32'(rd_req_ready), 0);
    end
    chk("lim_cnt_max", 32'(rd_outstanding), 4);
    cyc();
    rlast_pulse();
    chk("lim_cnt_dec", 32'(rd_outstanding), 3);
    @(negedge clk);
    chk("lim_5th_ready", 32'(rd_req_ready), 1);
    cyc();
    rd_req_valid = 0;
    cyc();
    bus_arready = 0;
    chk("lim_cnt_refill", 32'(rd_outstanding), 4);
    for (int i = 3; i >= 0; i--) begin
      rlast_pulse();
      chk("lim_drain", 32'(rd_outstanding), 32'(i));
    end

    // No read grant while a write burst is in its data phase
    set_wr(28'h0C00000, 4'd7, 4'd5, 1'b0);
    push(1, 28'h0C00000, 4'd7, 4'd5, 1'b0);
    bus_awready = 1; wr_req_valid = 1;
    wait_grant("wd_wr_grant", 1, 10);
    cyc();
    wr_req_valid = 0;
    set_rd(28'h0D00000, 4'd2, 4'd3, 1'b1);
    push(0, 28'h0D00000, 4'd2, 4'd3, 1'b1);
    rd_req_valid = 1;
    repeat (4) begin
      @(negedge clk);
      chk("wd_block", 32'(rd_req_ready), 0);
    end
    cyc();
    bus_awready = 0;
    bus_wready = 1; bus_wlast = 0; bus_wid = 4'd5;
    @(negedge clk);
    chk("wd_block_beat", 32'(rd_req_ready), 0);
    cyc();
    bus_wlast = 1;
    @(negedge clk);
    chk("wd_block_last", 32'(rd_req_ready), 0);
    cyc();
    bus_wready = 0; bus_wlast = 0;
    @(negedge clk);
    chk("wd_rd_after", 32'(rd_req_ready), 1);
    chk("wd_no_err", 32'(err_sticky), 0);
    cyc();
    rd_req_valid = 0; bus_arready = 1;
    cyc();
    bus_arready = 0;
    chk("wd_cnt", 32'(rd_outstanding), 1);
    rlast_pulse();

    // Orphan rlast, then simultaneous accept+rlast
    rlast_pulse();
    chk("orph_err", 32'(err_sticky), 1);
    chk("orph_cnt", 32'(rd_outstanding), 0);
    set_rd(28'h0E00000, 4'd0, 4'd1, 1'b0);
    push(0, 28'h0E00000, 4'd0, 4'd1, 1'b0);
    rd_req_valid = 1; bus_arready = 1;
    wait_grant("sim_g1", 0, 10);
    cyc();
    rd_req_valid = 0;
    cyc();
    bus_arready = 0;
    chk("sim_cnt1", 32'(rd_outstanding), 1);
    set_rd(28'h0E00010, 4'd0, 4'd2, 1'b0);
    push(0, 28'h0E00010, 4'd0, 4'd2, 1'b0);
    rd_req_valid = 1;
    wait_grant("sim_g2", 0, 10);
    cyc();
    rd_req_valid = 0;
    bus_arready = 1; bus_rvalid = 1; bus_rlast = 1;
    cyc();
    bus_arready = 0; bus_rvalid = 0; bus_rlast = 0;
    chk("sim_net0", 32'(rd_outstanding), 1);
    rlast_pulse();
    chk("sim_drain", 32'(rd_outstanding), 0);

    // Asynchronous reset during a write data phase
    set_rd(28'h0F00000, 4'd1, 4'd4, 1'b0);
    push(0, 28'h0F00000, 4'd1, 4'd4, 1'b0);
    rd_req_valid = 1; bus_arready = 1;
    wait_grant("ar_rd", 0, 10);
    cyc();
    rd_req_valid = 0;
    cyc();
    bus_arready = 0;
    set_wr(28'h0F10000, 4'd3, 4'd6, 1'b1);
    push(1, 28'h0F10000, 4'd3, 4'd6, 1'b1);
    wr_req_valid = 1; bus_awready = 1;
    wait_grant("ar_wr", 1, 10);
    cyc();
    wr_req_valid = 0;
    cyc();
    bus_awready = 0;
    chk("ar_pre_cnt", 32'(rd_outstanding), 1);
    #2 rst_n = 0;
    #1;
    chk("ar_addr", 32'(bus_addr), 0);
    chk("ar_len", 32'(bus_len), 0);
    chk("ar_id", 32'(bus_id), 0);
    chk("ar_ap", 32'(bus_ap), 0);
    chk("ar_arvalid", 32'(bus_arvalid), 0);
    chk("ar_awvalid", 32'(bus_awvalid), 0);
    chk("ar_cnt", 32'(rd_outstanding), 0);
    chk("ar_err", 32'(err_sticky), 0);
    @(negedge clk); rst_n = 1;
    cyc();
    set_rd(28'h0000200, 4'd0, 4'd8, 1'b0);
    push(0, 28'h0000200, 4'd0, 4'd8, 1'b0);
    rd_req_valid = 1;
    @(negedge clk);
    chk("ar_idle_ready", 32'(rd_req_ready), 1);
    cyc();
    rd_req_valid = 0; bus_arready = 1;
    cyc();
    bus_arready = 0;

    // Write last beat with the wrong id
    set_wr(28'h0123450, 4'd1, 4'd9, 1'b0);
    push(1, 28'h0123450, 4'd1, 4'd9, 1'b0);
    wr_req_valid = 1; bus_awready = 1;
    wait_grant("wid_grant", 1, 10);
    cyc();
    wr_req_valid = 0;
    cyc();
    bus_awready = 0;
    set_rd(28'h0000300, 4'd1, 4'd2, 1'b0);
    push(0, 28'h0000300, 4'd1, 4'd2, 1'b0);
    rd_req_valid = 1;
    bus_wready = 1; bus_wlast = 1; bus_wid = 4'd4;
    cyc();
    bus_wready = 0; bus_wlast = 0;
    chk("wid_err", 32'(err_sticky), 1);
    @(negedge clk);
    chk("wid_stay", 32'(rd_req_ready), 0);
    cyc();
    bus_wready = 1; bus_wlast = 1; bus_wid = 4'd9;
    cyc();
    bus_wready = 0; bus_wlast = 0;
    @(negedge clk);
    chk("wid_done", 32'(rd_req_ready), 1);
    cyc();
    rd_req_valid = 0; bus_arready = 1;
    cyc();
    bus_arready = 0;
    chk("wid_cnt", 32'(rd_outstanding), 2);

    repeat (3) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
